ysyx_25030093_ifu: RTL and testbench

//   Instruction fetch unit feeding the decode stage, which drives inst to the immediate generator.

---
 rtl/ysyx_25030093_ifu.sv | 142 ++++++++++++++
 tb/tb_ysyx_25030093_ifu.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_25030093_ifu.sv
// Instruction fetch unit: one memory read per instruction, handed to decode over valid/ready.
// Optional macro YSYX_25030093_IFU_MISALIGN_EN turns a misaligned PC into a local fetch fault.
module ysyx_25030093_ifu #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000,
    parameter int unsigned TIMEOUT  = 16,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        pc_wen,
    input  logic [31:0] pc_wdata,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic [31:0] mem_req_addr,
    input  logic        mem_rsp_valid,
    input  logic [31:0] mem_rsp_data,
    input  logic        mem_rsp_err,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    output logic        inst_err
);

    localparam int unsigned CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic TIMEOUT_EN = (TIMEOUT != 0);

    typedef enum logic [1:0] {
        S_REQ,
        S_WAIT_RSP,
        S_OUT,
        S_WAIT_WB
    } state_e;

    state_e             state_q, state_d;
    logic [31:0]        pc_q, pc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [31:0]        inst_q, inst_d;
    logic [31:0]        inst_pc_q, inst_pc_d;
    logic               inst_err_q, inst_err_d;
    logic               mem_req_valid_q, mem_req_valid_d;
    logic               inst_valid_q, inst_valid_d;
    logic               misalign_c;
    logic               misalign_next_c;

`ifdef YSYX_25030093_IFU_MISALIGN_EN
    assign misalign_c      = (pc_q[1:0] != 2'b00);
    assign misalign_next_c = (pc_d[1:0] != 2'b00);
`else
    assign misalign_c      = 1'b0;
    assign misalign_next_c = 1'b0;
`endif

    // Next-state and registered-output computation; outputs follow the next state.
    always_comb begin
        state_d         = state_q;
        pc_d            = pc_q;
        cnt_d           = cnt_q;
        inst_d          = inst_q;
        inst_pc_d       = inst_pc_q;
        inst_err_d      = inst_err_q;
        mem_req_valid_d = 1'b0;
        inst_valid_d    = 1'b0;

        case (state_q)
            S_REQ: begin
                if (misalign_c) begin
                    state_d    = S_OUT;
                    inst_d     = NOP_INST;
                    inst_err_d = 1'b1;
                    inst_pc_d  = pc_q;
                end else if (mem_req_valid_q && mem_req_ready) begin
                    state_d = S_WAIT_RSP;
                    cnt_d   = '0;
                end
            end
            S_WAIT_RSP: begin
                cnt_d = cnt_q + CNT_W'(1);
                // A response arriving on the expiry cycle still wins.
                if (mem_rsp_valid) begin
                    state_d    = S_OUT;
                    inst_d     = mem_rsp_err ? NOP_INST : mem_rsp_data;
                    inst_err_d = mem_rsp_err;
                    inst_pc_d  = pc_q;
                end else if (TIMEOUT_EN && (cnt_q == CNT_LAST)) begin
                    state_d    = S_OUT;
                    inst_d     = NOP_INST;
                    inst_err_d = 1'b1;
                    inst_pc_d  = pc_q;
                end
            end
            S_OUT: begin
                if (inst_valid_q && inst_ready) begin
                    state_d = S_WAIT_WB;
                end
            end
            S_WAIT_WB: begin
                if (pc_wen) begin
                    pc_d    = pc_wdata;
                    state_d = S_REQ;
                end
            end
            default: begin
                state_d = S_REQ;
            end
        endcase

        mem_req_valid_d = (state_d == S_REQ) && !misalign_next_c;
        inst_valid_d    = (state_d == S_OUT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= S_REQ;
            pc_q            <= RESET_PC;
            cnt_q           <= '0;
            inst_q          <= '0;
            inst_pc_q       <= '0;
            inst_err_q      <= 1'b0;
            mem_req_valid_q <= 1'b0;
            inst_valid_q    <= 1'b0;
        end else begin
            state_q         <= state_d;
            pc_q            <= pc_d;
            cnt_q           <= cnt_d;
            inst_q          <= inst_d;
            inst_pc_q       <= inst_pc_d;
            inst_err_q      <= inst_err_d;
            mem_req_valid_q <= mem_req_valid_d;
            inst_valid_q    <= inst_valid_d;
        end
    end

    assign mem_req_valid = mem_req_valid_q;
    assign mem_req_addr  = pc_q;
    assign inst_valid    = inst_valid_q;
    assign inst          = inst_q;
    assign inst_pc       = inst_pc_q;
    assign inst_err      = inst_err_q;

endmodule

// File: tb/tb_ysyx_25030093_ifu.sv
// Scenario bench for ysyx_25030093_ifu: directed cases plus randomized fetches against a transaction model.
module tb_ysyx_25030093_ifu;

    localparam logic [31:0] RST_PC = 32'h8000_0000;
    localparam logic [31:0] NOP    = 32'h0000_0013;
    localparam int          TMO    = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        pc_wen = 1'b0;
    logic [31:0] pc_wdata = '0;
    logic        mem_req_valid;
    logic        mem_req_ready = 1'b0;
    logic [31:0] mem_req_addr;
    logic        mem_rsp_valid = 1'b0;
    logic [31:0] mem_rsp_data = '0;
    logic        mem_rsp_err = 1'b0;
    logic        inst_valid;
    logic        inst_ready = 1'b0;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_err;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    ysyx_25030093_ifu dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .pc_wen        (pc_wen),
        .pc_wdata      (pc_wdata),
        .mem_req_valid (mem_req_valid),
        .mem_req_ready (mem_req_ready),
        .mem_req_addr  (mem_req_addr),
        .mem_rsp_valid (mem_rsp_valid),
        .mem_rsp_data  (mem_rsp_data),
        .mem_rsp_err   (mem_rsp_err),
        .inst_valid    (inst_valid),
        .inst_ready    (inst_ready),
        .inst          (inst),
        .inst_pc       (inst_pc),
        .inst_err      (inst_err)
    );

    // Drivers: every task starts and ends at a falling edge.
    task automatic pulse_wb(input logic [31:0] a);
        pc_wen = 1'b1; pc_wdata = a;
        @(negedge clk);
        pc_wen = 1'b0;
    endtask

    task automatic wait_req(output bit ok);
        int n = 0;
        while (!mem_req_valid && n < 40) begin @(negedge clk); n++; end
        ok = mem_req_valid;
    endtask

    task automatic issue_req(input int stall);
        repeat (stall) @(negedge clk);
        mem_req_ready = 1'b1;
        @(negedge clk);
        mem_req_ready = 1'b0;
    endtask

    task automatic respond(input int lat, input logic [31:0] d, input logic e);
        repeat (lat) @(negedge clk);
        mem_rsp_valid = 1'b1; mem_rsp_data = d; mem_rsp_err = e;
        @(negedge clk);
        mem_rsp_valid = 1'b0; mem_rsp_err = 1'b0;
    endtask

    task automatic accept(input int delay);
        repeat (delay) @(negedge clk);
        inst_ready = 1'b1;
        @(negedge clk);
        inst_ready = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        n_vec++; if (mem_req_valid !== 1'b0) begin n_err++; $display("FAIL rst_req_valid got=%b exp=0", mem_req_valid); end
        n_vec++; if (inst_valid !== 1'b0) begin n_err++; $display("FAIL rst_inst_valid got=%b exp=0", inst_valid); end
        n_vec++; if (inst_err !== 1'b0) begin n_err++; $display("FAIL rst_inst_err got=%b exp=0", inst_err); end
        n_vec++; if (inst !== 32'h0) begin n_err++; $display("FAIL rst_inst got=%h exp=0", inst); end
        n_vec++; if (inst_pc !== 32'h0) begin n_err++; $display("FAIL rst_inst_pc got=%h exp=0", inst_pc); end
        n_vec++; if (mem_req_addr !== RST_PC) begin n_err++; $display("FAIL rst_addr got=%h exp=%h", mem_req_addr, RST_PC); end
        rst_n = 1'b1;
    endtask

    task automatic test_basic;
        bit ok;
        wait_req(ok);
        n_vec++; if (!ok) begin n_err++; $display("FAIL basic_req_timeout got=0 exp=1"); end
        n_vec++; if (mem_req_addr !== RST_PC) begin n_err++; $display("FAIL basic_addr got=%h exp=%h", mem_req_addr, RST_PC); end
        issue_req(0);
        respond(0, 32'h0050_0093, 1'b0);
        n_vec++; if (inst_valid !== 1'b1) begin n_err++; $display("FAIL basic_valid got=%b exp=1", inst_valid); end
        n_vec++; if (inst !== 32'h0050_0093) begin n_err++; $display("FAIL basic_inst got=%h exp=00500093", inst); end
        n_vec++; if (inst_pc !== RST_PC) begin n_err++; $display("FAIL basic_pc got=%h exp=%h", inst_pc, RST_PC); end
        n_vec++; if (inst_err !== 1'b0) begin n_err++; $display("FAIL basic_err got=%b exp=0", inst_err); end
    endtask

    task automatic test_out_stall;
        logic [31:0] d;
        for (int i = 0; i < 5; i++) begin
            pc_wen = (i == 2); pc_wdata = 32'h1234_5670;
            @(negedge clk);
            pc_wen = 1'b0;
            n_vec++; if (inst_valid !== 1'b1 || inst !== 32'h0050_0093 || inst_pc !== RST_PC)
                begin n_err++; $display("FAIL out_hold[%0d] got=%b/%h/%h exp=1/00500093/%h", i, inst_valid, inst, inst_pc, RST_PC); end
            n_vec++; if (mem_req_valid !== 1'b0) begin n_err++; $display("FAIL out_wen_ignored[%0d] got=%b exp=0", i, mem_req_valid); end
        end
        accept(0);
        mem_rsp_valid = 1'b1; mem_rsp_data = 32'hDEAD_BEEF;
        @(negedge clk);
        mem_rsp_valid = 1'b0;
        n_vec++; if (inst_valid !== 1'b0 || mem_req_valid !== 1'b0) begin n_err++; $display("FAIL wb_idle got=%b/%b exp=0/0", inst_valid, mem_req_valid); end
        n_vec++; if (inst !== 32'h0050_0093) begin n_err++; $display("FAIL wb_spurious_rsp got=%h exp=00500093", inst); end
        // Zero-wait path: pc_wen to inst_valid in three cycles.
        d = $urandom;
        pc_wen = 1'b1; pc_wdata = 32'h8000_0004; mem_req_ready = 1'b1;
        @(negedge clk);
        pc_wen = 1'b0;
        n_vec++; if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h8000_0004)
            begin n_err++; $display("FAIL next_req got=%b/%h exp=1/80000004", mem_req_valid, mem_req_addr); end
        @(negedge clk);
        mem_req_ready = 1'b0; mem_rsp_valid = 1'b1; mem_rsp_data = d;
        @(negedge clk);
        mem_rsp_valid = 1'b0;
        n_vec++; if (inst_valid !== 1'b1) begin n_err++; $display("FAIL latency3 got=%b exp=1", inst_valid); end
        n_vec++; if (inst !== d || inst_pc !== 32'h8000_0004) begin n_err++; $display("FAIL next_inst got=%h/%h exp=%h/80000004", inst, inst_pc, d); end
        accept(0);
    endtask

    task automatic test_req_stall;
        pulse_wb(32'h8000_0008);
        for (int i = 0; i < 3; i++) begin
            n_vec++; if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h8000_0008)
                begin n_err++; $display("FAIL req_hold[%0d] got=%b/%h exp=1/80000008", i, mem_req_valid, mem_req_addr); end
            @(negedge clk);
        end
        issue_req(0);
        n_vec++; if (mem_req_valid !== 1'b0) begin n_err++; $display("FAIL req_single got=%b exp=0", mem_req_valid); end
        respond(1, 32'hCAFE_0001, 1'b1);
        n_vec++; if (inst_valid !== 1'b1 || inst !== NOP || inst_err !== 1'b1 || inst_pc !== 32'h8000_0008)
            begin n_err++; $display("FAIL bus_err got=%b/%h/%b/%h exp=1/%h/1/80000008", inst_valid, inst, inst_err, inst_pc, NOP); end
        accept(0);
    endtask

    task automatic test_timeout;
        int cyc = 0;
        pulse_wb(32'h8000_000C);
        issue_req(0);
        while (!inst_valid && cyc < 40) begin @(negedge clk); cyc++; end
        n_vec++; if (cyc != TMO) begin n_err++; $display("FAIL timeout_cycles got=%0d exp=%0d", cyc, TMO); end
        n_vec++; if (inst !== NOP || inst_err !== 1'b1 || inst_pc !== 32'h8000_000C)
            begin n_err++; $display("FAIL timeout_inst got=%h/%b/%h exp=%h/1/8000000c", inst, inst_err, inst_pc, NOP); end
        accept(0);
    endtask

    task automatic test_misalign;
        logic [31:0] d;
        d = $urandom;
        pulse_wb(32'h8000_0002);
`ifdef YSYX_25030093_IFU_MISALIGN_EN
        n_vec++; if (mem_req_valid !== 1'b0) begin n_err++; $display("FAIL misalign_noreq got=%b exp=0", mem_req_valid); end
        @(negedge clk);
        n_vec++; if (inst_valid !== 1'b1 || inst !== NOP || inst_err !== 1'b1 || inst_pc !== 32'h8000_0002)
            begin n_err++; $display("FAIL misalign_inst got=%b/%h/%b/%h exp=1/%h/1/80000002", inst_valid, inst, inst_err, inst_pc, NOP); end
`else
        n_vec++; if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h8000_0002)
            begin n_err++; $display("FAIL unaligned_req got=%b/%h exp=1/80000002", mem_req_valid, mem_req_addr); end
        issue_req(0);
        respond(0, d, 1'b0);
        n_vec++; if (inst_valid !== 1'b1 || inst !== d || inst_err !== 1'b0 || inst_pc !== 32'h8000_0002)
            begin n_err++; $display("FAIL unaligned_inst got=%b/%h/%b/%h exp=1/%h/0/80000002", inst_valid, inst, inst_err, inst_pc, d); end
`endif
        accept(0);
    endtask

    task automatic test_reset_mid;
        bit ok;
        pulse_wb(32'h8000_0010);
        issue_req(0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_vec++; if (mem_req_valid !== 1'b0 || inst_valid !== 1'b0 || inst_err !== 1'b0 || inst !== 32'h0 || inst_pc !== 32'h0)
            begin n_err++; $display("FAIL midrst_outs got=%b/%b/%b/%h/%h exp=0/0/0/0/0", mem_req_valid, inst_valid, inst_err, inst, inst_pc); end
        @(negedge clk);
        rst_n = 1'b1;
        mem_rsp_valid = 1'b1; mem_rsp_data = 32'hBAD0_BAD0;
        @(negedge clk);
        mem_rsp_valid = 1'b0;
        n_vec++; if (inst_valid !== 1'b0) begin n_err++; $display("FAIL midrst_stale_rsp got=%b exp=0", inst_valid); end
        wait_req(ok);
        n_vec++; if (!ok || mem_req_addr !== RST_PC) begin n_err++; $display("FAIL midrst_refetch got=%b/%h exp=1/%h", ok, mem_req_addr, RST_PC); end
    endtask

    // Randomized fetches; entered with a request pending at RST_PC.
    task automatic test_random;
        logic [31:0] pc_m, d, exp_inst, nxt;
        logic        e, exp_err, junk;
        int          lat;
        bit          ok;
        pc_m = RST_PC;
        for (int it = 0; it < 40; it++) begin
            d   = $urandom;
            e   = ($urandom_range(0, 5) == 0);
            lat = ($urandom_range(0, 7) == 0) ? $urandom_range(14, 20) : $urandom_range(0, 4);
            exp_inst = (lat < TMO) ? (e ? NOP : d) : NOP;
            exp_err  = (lat < TMO) ? e : 1'b1;
            wait_req(ok);
            n_vec++; if (!ok || mem_req_addr !== pc_m) begin n_err++; $display("FAIL rnd_req[%0d] got=%b/%h exp=1/%h", it, ok, mem_req_addr, pc_m); end
            issue_req($urandom_range(0, 3));
            respond(lat, d, e);
            n_vec++; if (inst_valid !== 1'b1 || inst !== exp_inst || inst_err !== exp_err || inst_pc !== pc_m)
                begin n_err++; $display("FAIL rnd_inst[%0d] got=%b/%h/%b/%h exp=1/%h/%b/%h", it, inst_valid, inst, inst_err, inst_pc, exp_inst, exp_err, pc_m); end
            repeat ($urandom_range(0, 3)) @(negedge clk);
            junk = $urandom_range(0, 1);
            inst_ready = 1'b1; pc_wen = junk; pc_wdata = 32'hFFFF_FFF0;
            @(negedge clk);
            inst_ready = 1'b0; pc_wen = 1'b0;
            n_vec++; if (inst_valid !== 1'b0 || mem_req_valid !== 1'b0)
                begin n_err++; $display("FAIL rnd_accept[%0d] got=%b/%b exp=0/0", it, inst_valid, mem_req_valid); end
            nxt = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
            repeat ($urandom_range(0, 2)) @(negedge clk);
            pulse_wb(nxt);
            pc_m = nxt;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got=running exp=finished");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_basic();
        test_out_stall();
        test_req_stall();
        test_timeout();
        test_misalign();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
